// File: rtl/aoc2_pkg.sv
// Shared definitions for the day-2 range parser: ASCII codes, parser states,
// the emitted range record, and small byte-classification helpers.
package aoc2_pkg;

    localparam int AOC2_DATA_WIDTH = 64;
    localparam int AOC2_MAX_DIGS   = 11;
    localparam int DIGS_W          = 4;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_DASH  = 8'h2D;
    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SP    = 8'h20;

    typedef enum logic [2:0] {
        ST_LO,
        ST_HI,
        ST_EMIT,
        ST_DONE,
        ST_ERR
    } parse_state_t;

    typedef struct packed {
        logic [AOC2_DATA_WIDTH-1:0] lo;
        logic [AOC2_DATA_WIDTH-1:0] hi;
        logic [DIGS_W-1:0]          lo_digs;
        logic [DIGS_W-1:0]          hi_digs;
    } range_rec_t;

    function automatic logic ch_is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

    // Record terminators: comma between pairs, newline at end of line
    function automatic logic ch_is_term(input logic [7:0] c);
        return (c == CH_COMMA) || (c == CH_NL);
    endfunction

    // Whitespace that is silently skipped
    function automatic logic ch_is_blank(input logic [7:0] c);
        return (c == CH_SP) || (c == CH_CR);
    endfunction

endpackage

// File: rtl/aoc2_dec_accum.sv
// Decimal accumulator: acc <= acc*10 + digit with a digit counter.
// o_acc_next/o_digs_next expose the post-digit value so a final digit can be
// captured in the same cycle it arrives. o_ovf warns that one more digit
// would exceed MAX_DIGS.
module aoc2_dec_accum
    import aoc2_pkg::*;
#(
    parameter int DATA_WIDTH = AOC2_DATA_WIDTH,
    parameter int MAX_DIGS   = AOC2_MAX_DIGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_digit_en,
    input  logic [3:0]            i_digit,
    output logic [DATA_WIDTH-1:0] o_acc,
    output logic [DATA_WIDTH-1:0] o_acc_next,
    output logic [DIGS_W-1:0]     o_digs,
    output logic [DIGS_W-1:0]     o_digs_next,
    output logic                  o_ovf
);

    logic [DATA_WIDTH-1:0] r_acc;
    logic [DIGS_W-1:0]     r_digs;

    // x*10 as x*8 + x*2 keeps this to two adders
    assign o_acc_next  = (r_acc << 3) + (r_acc << 1) + DATA_WIDTH'(i_digit);
    assign o_digs_next = r_digs + DIGS_W'(1);
    assign o_ovf       = (r_digs == DIGS_W'(MAX_DIGS));
    assign o_acc       = r_acc;
    assign o_digs      = r_digs;

    // Accumulate one digit per enabled cycle; clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_digs <= '0;
        end else if (i_clear) begin
            r_acc  <= '0;
            r_digs <= '0;
        end else if (i_digit_en) begin
            r_acc  <= o_acc_next;
            r_digs <= o_digs_next;
        end
    end

endmodule

// File: rtl/aoc2_range_parser.sv
// Streaming ASCII "lo-hi,lo-hi,...\n" parser. Emits one (lo, hi, digit counts)
// record per pair through a valid/ready port. Malformed input latches err and
// halts; the end of stream latches done once the last record has drained.
module aoc2_range_parser
    import aoc2_pkg::*;
#(
    parameter int DATA_WIDTH = AOC2_DATA_WIDTH,
    parameter int MAX_DIGS   = AOC2_MAX_DIGS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_byte,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [3:0]            lo_digs,
    output logic [3:0]            hi_digs,
    output logic                  done,
    output logic                  err
);

    parse_state_t          r_state, w_state_next;
    logic                  r_pend, w_pend_next;
    logic [DATA_WIDTH-1:0] r_lo, r_hi;
    logic [DIGS_W-1:0]     r_lo_digs, r_hi_digs;

    logic [DATA_WIDTH-1:0] w_acc, w_acc_next;
    logic [DIGS_W-1:0]     w_digs, w_digs_next;
    logic                  w_ovf;
    logic                  w_acc_clear, w_acc_digit;
    logic                  w_cap_lo, w_cap_hi, w_hi_from_next;
    logic                  w_accept, w_ctx_hi, w_digs_zero;
    parse_state_t          w_ctx_state;

    aoc2_dec_accum #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_DIGS   (MAX_DIGS)
    ) u_accum (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_acc_clear),
        .i_digit_en  (w_acc_digit),
        .i_digit     (in_byte[3:0]),
        .o_acc       (w_acc),
        .o_acc_next  (w_acc_next),
        .o_digs      (w_digs),
        .o_digs_next (w_digs_next),
        .o_ovf       (w_ovf)
    );

    // While a record drains (out_ready high) the next byte is already taken and
    // parsed as the start of a new lo field, unless the stream has ended.
    assign in_ready    = (r_state == ST_LO) || (r_state == ST_HI) ||
                         ((r_state == ST_EMIT) && out_ready && !r_pend);
    assign w_accept    = in_valid && in_ready;
    assign w_ctx_hi    = (r_state == ST_HI);
    assign w_ctx_state = w_ctx_hi ? ST_HI : ST_LO;
    assign w_digs_zero = (w_digs == '0);

    assign out_valid = (r_state == ST_EMIT);
    assign done      = (r_state == ST_DONE);
    assign err       = (r_state == ST_ERR);
    assign lo        = r_lo;
    assign hi        = r_hi;
    assign lo_digs   = r_lo_digs;
    assign hi_digs   = r_hi_digs;

    // Next state and datapath controls from the accepted byte's class
    always_comb begin
        w_state_next   = r_state;
        w_pend_next    = r_pend;
        w_acc_clear    = 1'b0;
        w_acc_digit    = 1'b0;
        w_cap_lo       = 1'b0;
        w_cap_hi       = 1'b0;
        w_hi_from_next = 1'b0;

        if ((r_state == ST_EMIT) && out_ready) begin
            w_state_next = r_pend ? ST_DONE : ST_LO;
        end

        if (w_accept) begin
            w_state_next = w_ctx_state;
            if (ch_is_digit(in_byte)) begin
                if (w_ovf) begin
                    w_state_next = ST_ERR;
                end else if (in_last) begin
                    // Final digit of hi closes the record implicitly
                    if (w_ctx_hi) begin
                        w_cap_hi       = 1'b1;
                        w_hi_from_next = 1'b1;
                        w_acc_clear    = 1'b1;
                        w_pend_next    = 1'b1;
                        w_state_next   = ST_EMIT;
                    end else begin
                        w_state_next = ST_ERR;
                    end
                end else begin
                    w_acc_digit = 1'b1;
                end
            end else if (in_byte == CH_DASH) begin
                if (!w_ctx_hi && !w_digs_zero && !in_last) begin
                    w_cap_lo     = 1'b1;
                    w_acc_clear  = 1'b1;
                    w_state_next = ST_HI;
                end else begin
                    w_state_next = ST_ERR;
                end
            end else if (ch_is_term(in_byte)) begin
                if (w_ctx_hi) begin
                    if (!w_digs_zero) begin
                        w_cap_hi     = 1'b1;
                        w_acc_clear  = 1'b1;
                        w_pend_next  = in_last;
                        w_state_next = ST_EMIT;
                    end else begin
                        w_state_next = ST_ERR;
                    end
                end else if (w_digs_zero) begin
                    // Empty record: nothing to emit
                    w_state_next = in_last ? ST_DONE : ST_LO;
                end else begin
                    w_state_next = ST_ERR;
                end
            end else if (ch_is_blank(in_byte)) begin
                if (in_last) begin
                    if (w_ctx_hi && !w_digs_zero) begin
                        w_cap_hi     = 1'b1;
                        w_acc_clear  = 1'b1;
                        w_pend_next  = 1'b1;
                        w_state_next = ST_EMIT;
                    end else if (!w_ctx_hi && w_digs_zero) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_ERR;
                    end
                end
            end else begin
                w_state_next = ST_ERR;
            end
        end
    end

    // Parser state and end-of-stream marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LO;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
        end
    end

    // Record fields: lo captured on '-', hi on the terminator; held through EMIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo      <= '0;
            r_hi      <= '0;
            r_lo_digs <= '0;
            r_hi_digs <= '0;
        end else begin
            if (w_cap_lo) begin
                r_lo      <= w_acc;
                r_lo_digs <= w_digs;
            end
            if (w_cap_hi) begin
                r_hi      <= w_hi_from_next ? w_acc_next : w_acc;
                r_hi_digs <= w_hi_from_next ? w_digs_next : w_digs;
            end
        end
    end

endmodule

// File: tb/tb_aoc2_range_parser.sv
// Bench for aoc2_range_parser: directed vector table, stall and reset
// sequences, then random streams scored against a text-level parse model.
`timescale 1ns/1ps
module tb_aoc2_range_parser;
    import aoc2_pkg::*;

    localparam int MAXD = 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, done, err;
    logic [63:0] lo, hi;
    logic [3:0]  lo_digs, hi_digs;

    always #5 clk = ~clk;

    aoc2_range_parser dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lo        (lo),
        .hi        (hi),
        .lo_digs   (lo_digs),
        .hi_digs   (hi_digs),
        .done      (done),
        .err       (err)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    range_rec_t exp_q[$];
    int         or_mode = 1;   // 0: random out_ready, 1: always 1, 2: held 0
    bit         m_err, m_done;
    int         m_n;

    typedef struct {
        string      txt;
        bit         last;
        int         n_rec;
        range_rec_t r0;
        range_rec_t r1;
        int         n_acc;
        bit         e;
        bit         d;
    } vec_t;
    vec_t vt[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic range_rec_t mk_rec(longint unsigned l, longint unsigned h, int ld, int hd);
        range_rec_t r;
        r.lo = l; r.hi = h; r.lo_digs = 4'(ld); r.hi_digs = 4'(hd);
        return r;
    endfunction

    task automatic add_vec(input string t, input bit l, input int nr, input range_rec_t a,
                           input range_rec_t b, input int na, input bit e, input bit d);
        vec_t v;
        v.txt = t; v.last = l; v.n_rec = nr; v.r0 = a; v.r1 = b; v.n_acc = na; v.e = e; v.d = d;
        vt.push_back(v);
    endtask

    // out_ready driver
    initial forever begin
        @(posedge clk); #1;
        case (or_mode)
            0:       out_ready = ($urandom_range(0, 9) < 7);
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
    end

    // Record scoreboard: one line per delivered record
    initial forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            range_rec_t e;
            if (exp_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL unexpected_record: got lo=%0d hi=%0d, required no record", lo, hi);
            end else begin
                e = exp_q.pop_front();
                $display("record lo=%0d hi=%0d lo_digs=%0d hi_digs=%0d", lo, hi, lo_digs, hi_digs);
                check("rec_lo", lo, e.lo);
                check("rec_hi", hi, e.hi);
                check("rec_lo_digs", 64'(lo_digs), 64'(e.lo_digs));
                check("rec_hi_digs", 64'(hi_digs), 64'(e.hi_digs));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Feed bytes; stops early once the parser has halted
    task automatic send_stream(input string s, input bit use_last, output int n_acc);
        bit stop;
        int w;
        stop = 1'b0;
        n_acc = 0;
        for (int i = 0; i < s.len() && !stop; i++) begin
            in_valid = 1'b1;
            in_byte  = s[i];
            in_last  = use_last && (i == s.len() - 1);
            w = 0;
            while (1) begin
                @(negedge clk);
                if (err || done) begin stop = 1'b1; break; end
                if (in_ready) break;
                w++;
                if (w > 40) begin
                    n_checks++; n_errors++;
                    $display("FAIL byte_timeout: got in_ready=0 for 40 cycles, required 1");
                    stop = 1'b1;
                    break;
                end
            end
            if (!stop) n_acc++;
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_drain(input string tag);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 60) begin @(negedge clk); w++; end
        check({tag, "_missing_records"}, 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_check(input string tag, input string s, input bit use_last,
                             input int exp_nacc, input bit exp_err, input bit exp_done);
        int nacc;
        send_stream(s, use_last, nacc);
        wait_drain(tag);
        check({tag, "_accepted"}, 64'(nacc), 64'(exp_nacc));
        check({tag, "_err"}, 64'(err), 64'(exp_err));
        check({tag, "_done"}, 64'(done), 64'(exp_done));
        if (exp_err) begin
            check({tag, "_err_in_ready"}, 64'(in_ready), 64'd0);
            check({tag, "_err_out_valid"}, 64'(out_valid), 64'd0);
        end
        $display("stream %s: accepted=%0d err=%0b done=%0b", tag, nacc, err, done);
    endtask

    // Reference parse of a whole text: fills exp_q, m_err, m_done, m_n
    task automatic model_run(input string s, input bit use_last);
        longint unsigned v, lov;
        int dg, lod;
        bit in_hi, last;
        logic [7:0] c;
        v = 0; lov = 0; dg = 0; lod = 0; in_hi = 0;
        m_err = 0; m_done = 0; m_n = 0;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            last = use_last && (i == s.len() - 1);
            m_n = i + 1;
            if (c >= CH_0 && c <= CH_9) begin
                if (dg == MAXD) begin m_err = 1; return; end
                v = v * 10 + 64'(c - CH_0);
                dg++;
                if (last) begin
                    if (in_hi) begin exp_q.push_back(mk_rec(lov, v, lod, dg)); m_done = 1; end
                    else m_err = 1;
                    return;
                end
            end else if (c == CH_DASH) begin
                if (in_hi || dg == 0 || last) begin m_err = 1; return; end
                lov = v; lod = dg; v = 0; dg = 0; in_hi = 1;
            end else if (c == CH_COMMA || c == CH_NL) begin
                if (in_hi) begin
                    if (dg == 0) begin m_err = 1; return; end
                    exp_q.push_back(mk_rec(lov, v, lod, dg));
                    v = 0; dg = 0; in_hi = 0;
                end else if (dg != 0) begin
                    m_err = 1; return;
                end
                if (last) m_done = 1;
            end else if (c == CH_SP || c == CH_CR) begin
                if (last) begin
                    if (!in_hi && dg == 0) m_done = 1;
                    else if (in_hi && dg > 0) begin exp_q.push_back(mk_rec(lov, v, lod, dg)); m_done = 1; end
                    else m_err = 1;
                end
            end else begin
                m_err = 1; return;
            end
        end
    endtask

    function automatic string rand_num();
        string s;
        int nd;
        s = "";
        nd = ($urandom_range(0, 19) == 0) ? 12 : $urandom_range(1, 11);
        for (int i = 0; i < nd; i++) s = $sformatf("%s%0d", s, $urandom_range(0, 9));
        return s;
    endfunction

    task automatic gen_stream(output string s);
        int nrec;
        nrec = $urandom_range(1, 4);
        s = "";
        for (int r = 0; r < nrec; r++) begin
            if ($urandom_range(0, 5) == 0) s = {s, ","};
            s = {s, rand_num()};
            if ($urandom_range(0, 3) == 0) s = {s, " "};
            s = {s, "-"};
            if ($urandom_range(0, 4) == 0) s = $sformatf("%s%c", s, CH_CR);
            s = {s, rand_num()};
            if (r != nrec - 1) s = {s, ($urandom_range(0, 1) != 0) ? "," : "\n"};
        end
        case ($urandom_range(0, 5))
            0:       ;                                             // ends on a hi digit
            1:       s.putc($urandom_range(0, s.len() - 1), 8'h78); // stray 'x'
            default: s = {s, "\n"};
        endcase
    endtask

    initial begin
        range_rec_t z;
        int nacc;
        int w;
        string s;
        z = mk_rec(0, 0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_lo", lo, 64'd0);
        check("rst_hi", hi, 64'd0);
        check("rst_digs", 64'({lo_digs, hi_digs}), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst = 1'b0;

        // Directed vectors
        add_vec("11-22,95-115\n", 1, 2, mk_rec(11, 22, 2, 2), mk_rec(95, 115, 2, 3), 13, 0, 1);
        add_vec("998-1012", 1, 1, mk_rec(998, 1012, 3, 4), z, 8, 0, 1);
        add_vec(",,\n1-9,", 1, 1, mk_rec(1, 9, 1, 1), z, 7, 0, 1);
        add_vec("123456789012-1", 1, 0, z, z, 12, 1, 0);
        add_vec("5-x", 1, 0, z, z, 3, 1, 0);
        add_vec("7--8", 1, 0, z, z, 3, 1, 0);
        add_vec("12- 3\015\n", 1, 1, mk_rec(12, 3, 2, 1), z, 7, 0, 1);
        add_vec("99999999999-0\n", 1, 1, mk_rec(64'd99999999999, 0, 11, 1), z, 14, 0, 1);
        add_vec("007-08\n", 1, 1, mk_rec(7, 8, 3, 2), z, 7, 0, 1);
        add_vec("\n", 1, 0, z, z, 1, 0, 1);
        add_vec("-5", 1, 0, z, z, 1, 1, 0);
        add_vec("1-", 1, 0, z, z, 2, 1, 0);
        add_vec("12,3-4\n", 1, 0, z, z, 3, 1, 0);
        add_vec("4-,5", 1, 0, z, z, 3, 1, 0);
        add_vec("3-4\n", 0, 1, mk_rec(3, 4, 1, 1), z, 4, 0, 0);

        foreach (vt[i]) begin
            do_reset();
            or_mode = (i % 2 == 0) ? 1 : 0;
            if (vt[i].n_rec > 0) exp_q.push_back(vt[i].r0);
            if (vt[i].n_rec > 1) exp_q.push_back(vt[i].r1);
            run_check($sformatf("vec%0d", i), vt[i].txt, vt[i].last, vt[i].n_acc, vt[i].e, vt[i].d);
        end

        // Downstream stall: record held, input blocked, no bytes lost
        do_reset();
        or_mode = 2;
        exp_q.push_back(mk_rec(11, 22, 2, 2));
        exp_q.push_back(mk_rec(95, 115, 2, 3));
        fork
            begin
                int na;
                send_stream("11-22,95-115\n", 1, na);
                check("stall_accepted", 64'(na), 64'd13);
            end
            begin
                w = 0;
                while (!out_valid && w < 100) begin @(negedge clk); w++; end
                check("stall_valid_seen", 64'(out_valid), 64'd1);
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    check("stall_out_valid", 64'(out_valid), 64'd1);
                    check("stall_lo", lo, 64'd11);
                    check("stall_hi", hi, 64'd22);
                end
                or_mode = 1;
            end
        join
        wait_drain("stall");
        check("stall_done", 64'(done), 64'd1);
        check("stall_err", 64'(err), 64'd0);
        $display("stream stall: done=%0b err=%0b", done, err);

        // Reset mid-record discards the partial pair
        do_reset();
        or_mode = 1;
        send_stream("12-3", 0, nacc);
        check("midrst_accepted", 64'(nacc), 64'd4);
        #3 rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_lo", lo, 64'd0);
        check("midrst_err_done", 64'({err, done}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(mk_rec(4, 5, 1, 1));
        run_check("midrst_after", "4-5\n", 1, 4, 0, 1);

        // Random streams against the text-level model
        for (int k = 0; k < 40; k++) begin
            gen_stream(s);
            do_reset();
            or_mode = 0;
            model_run(s, 1);
            run_check($sformatf("rand%0d", k), s, 1, m_n, m_err, m_done);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
